// File: rtl/fp_norm_round_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_norm_round_if
// Description : Handshake and data bundle for the fp_norm_round stage.
//               Upstream side: in_valid/in_ready with the unnormalised sum
//               (sign, exponent, mantissa, NaN/Inf tags).
//               Downstream side: out_valid/out_ready with the packed result
//               and its overflow/underflow qualifiers.
//               Modports:
//                 master - the environment (drives inputs, accepts results)
//                 slave  - the fp_norm_round block itself
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_norm_round_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  parameter int N     = 16
);
  logic               in_valid;
  logic               in_ready;
  logic               in_sign;
  logic [EXP_W+1:0]   in_exp;
  logic [MAN_W+4:0]   in_mant;
  logic               in_nan;
  logic               in_inf;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       out_data;
  logic               out_ovf;
  logic               out_unf;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_unf
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_unf
  );
endinterface
`default_nettype wire

// File: rtl/fp_norm_round.sv
`default_nettype none
// ============================================================================
// Module      : fp_norm_round
// Description : Two-stage normalise / round-to-nearest-even stage for the
//               16-bit float format {sign, 8-bit exp (bias 127), 7-bit frac}.
//               Stage 1 normalises the adder sum (carry right shift or
//               leading-zero left shift); stage 2 rounds, handles the
//               NaN/Inf/zero tags and the exponent range limits.
// Ports       : clock       - clock
//               nreset      - asynchronous active-low reset
//               bus         - fp_norm_round_if.slave (valid/ready in and out)
//               status_clr  - clears the sticky status register
//               status      - sticky {inexact, ovf, unf}
// Options     : FP_NORM_STATUS_EN - when defined, status is a sticky register
//               OR-set on every output transfer; otherwise status reads 0.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_norm_round #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  parameter int N     = 16
) (
  input  wire logic        clock,
  input  wire logic        nreset,
  fp_norm_round_if.slave   bus,
  input  wire logic        status_clr,
  output logic [2:0]       status
);

  // Normalised mantissa keeps hidden..sticky (the carry slot is gone).
  localparam int NW  = MAN_W + 4;
  localparam int LZW = $clog2(NW + 1);
  // Internal exponent has headroom so +1 / -lz never wraps.
  localparam int XW  = EXP_W + 3;

  localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
  localparam logic signed [XW-1:0] EXP_ZERO = XW'(0);
  localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic out_valid_q;
  logic stall;

  assign stall        = out_valid_q & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  // --------------------------------------------------------------------------
  // Stage 1: normalise
  // --------------------------------------------------------------------------
  function automatic logic [LZW-1:0] f_lz(input logic [NW-1:0] m);
    logic [LZW-1:0] n;
    logic           found;
    n     = '0;
    found = 1'b0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) found = 1'b1;
        else      n     = n + 1'b1;
      end
    end
    return n;
  endfunction

  logic signed [XW-1:0] exp_in;
  logic [LZW-1:0]       lz;
  logic [NW-1:0]        s1_mant_d;
  logic signed [XW-1:0] s1_exp_d;
  logic                 s1_zero_d;

  assign exp_in = {bus.in_exp[EXP_W+1], bus.in_exp};

  always_comb begin
    lz        = f_lz(bus.in_mant[NW-1:0]);
    s1_zero_d = (bus.in_mant == '0);
    if (bus.in_mant[NW]) begin
      // Carry out of the adder: shift right once, folding R|S into sticky.
      s1_mant_d = {bus.in_mant[NW:2], bus.in_mant[1] | bus.in_mant[0]};
      s1_exp_d  = exp_in + EXP_ONE;
    end else begin
      s1_mant_d = bus.in_mant[NW-1:0] << lz;
      s1_exp_d  = exp_in - $signed({{(XW-LZW){1'b0}}, lz});
    end
  end

  logic                 s1_valid_q;
  logic                 s1_sign_q;
  logic signed [XW-1:0] s1_exp_q;
  logic [NW-1:0]        s1_mant_q;
  logic                 s1_nan_q;
  logic                 s1_inf_q;
  logic                 s1_zero_q;

  // --------------------------------------------------------------------------
  // Stage 2: round to nearest even, special cases, range limits
  // --------------------------------------------------------------------------
  logic                 g_bit, r_bit, s_bit, lsb_bit, round_up;
  logic [MAN_W+1:0]     rnd_sum;
  logic [MAN_W-1:0]     rnd_frac;
  logic signed [XW-1:0] rnd_exp;
  logic [N-1:0]         out_data_d;
  logic                 out_ovf_d;
  logic                 out_unf_d;
  logic                 out_inex_d;

  assign g_bit    = s1_mant_q[2];
  assign r_bit    = s1_mant_q[1];
  assign s_bit    = s1_mant_q[0];
  assign lsb_bit  = s1_mant_q[3];
  assign round_up = g_bit & (r_bit | s_bit | lsb_bit);
  assign rnd_sum  = {1'b0, s1_mant_q[NW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};

  always_comb begin
    // Rounding up from 1.11..1 reaches 2.0: renormalise by bumping exp.
    if (rnd_sum[MAN_W+1]) begin
      rnd_frac = '0;
      rnd_exp  = s1_exp_q + EXP_ONE;
    end else begin
      rnd_frac = rnd_sum[MAN_W-1:0];
      rnd_exp  = s1_exp_q;
    end
  end

  always_comb begin
    out_data_d = '0;
    out_ovf_d  = 1'b0;
    out_unf_d  = 1'b0;
    out_inex_d = g_bit | r_bit | s_bit;
    if (s1_nan_q) begin
      out_data_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      out_inex_d = 1'b0;
    end else if (s1_inf_q) begin
      out_data_d = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      out_inex_d = 1'b0;
    end else if (s1_zero_q) begin
      out_data_d = '0;
    end else if (rnd_exp >= EXP_MAX) begin
      out_data_d = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      out_ovf_d  = 1'b1;
    end else if (rnd_exp <= EXP_ZERO) begin
      out_data_d = {s1_sign_q, {(N-1){1'b0}}};
      out_unf_d  = 1'b1;
    end else begin
      out_data_d = {s1_sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
    end
    // Flags only mean something on a real beat.
    out_ovf_d  = out_ovf_d  & s1_valid_q;
    out_unf_d  = out_unf_d  & s1_valid_q;
    out_inex_d = out_inex_d & s1_valid_q;
  end

  logic [N-1:0] out_data_q;
  logic         out_ovf_q;
  logic         out_unf_q;
  logic         out_inex_q;

  // --------------------------------------------------------------------------
  // Pipeline registers: both stages advance together unless stalled.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_mant_q   <= '0;
      s1_nan_q    <= 1'b0;
      s1_inf_q    <= 1'b0;
      s1_zero_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
      out_inex_q  <= 1'b0;
    end else if (!stall) begin
      s1_valid_q  <= bus.in_valid;
      s1_sign_q   <= bus.in_sign;
      s1_exp_q    <= s1_exp_d;
      s1_mant_q   <= s1_mant_d;
      s1_nan_q    <= bus.in_nan;
      s1_inf_q    <= bus.in_inf;
      s1_zero_q   <= s1_zero_d;
      out_valid_q <= s1_valid_q;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_unf_q   <= out_unf_d;
      out_inex_q  <= out_inex_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_unf   = out_unf_q;

  // --------------------------------------------------------------------------
  // Sticky status
  // --------------------------------------------------------------------------
  logic unused_ok;

`ifdef FP_NORM_STATUS_EN
  logic [2:0] status_q;
  logic [2:0] status_d;
  logic       out_xfer;

  assign out_xfer = out_valid_q & bus.out_ready;

  // Clear drops history, but an event in the same cycle still lands.
  always_comb begin
    status_d = status_clr ? 3'b000 : status_q;
    if (out_xfer) status_d = status_d | {out_inex_q, out_ovf_q, out_unf_q};
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) status_q <= 3'b000;
    else         status_q <= status_d;
  end

  assign status    = status_q;
  assign unused_ok = rnd_sum[MAN_W];
`else
  assign status    = 3'b000;
  assign unused_ok = rnd_sum[MAN_W] | status_clr | out_inex_q;
`endif

endmodule
`default_nettype wire

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
- Post-add normalise/round stage for the team's 16-bit float format: 1 sign bit, 8-bit biased exponent with bias 127, 7-bit fraction.
- Sits directly downstream of the pipelined adder. Consumes an unnormalised sum with carry, hidden, guard, round and sticky bits, and produces a packed, correctly rounded result.
- Two-stage pipeline with a valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 7, fraction field width (hidden bit excluded).
- N, 16, packed result width; must equal 1+EXP_W+MAN_W.

Ports:
- clock  in  1  clock.
- nreset  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_sign  in  1  sign of the sum.
- in_exp  in  EXP_W+2  biased exponent, two's complement, so it can go below 0 or above 2^EXP_W-1.
- in_mant  in  MAN_W+5  mantissa layout: [MAN_W+4] carry, [MAN_W+3] hidden, [MAN_W+2:3] fraction, [2] guard, [1] round, [0] sticky.
- in_nan  in  1  special-case bypass: NaN.
- in_inf  in  1  special-case bypass: infinity (in_nan has priority).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  N  packed result {sign, exp, frac}.
- out_ovf  out  1  result overflowed to infinity.
- out_unf  out  1  result flushed to zero.
- status_clr  in  1  clears the sticky status register.
- status  out  3  sticky flags {inexact, ovf, unf}.

Behaviour:
- Reset: every pipeline register, out_valid, out_data, out_ovf, out_unf and status go to 0. A reset mid-operation drops all in-flight beats.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational.
  - A beat transfers on in_valid & in_ready; output is consumed on out_valid & out_ready.
  - When not stalled, both stages advance every cycle; bubbles propagate as valid=0.
  - During a stall, all stage registers and outputs hold exactly.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput: 1 beat per cycle.
- Stage 1 (normalise):
  - Carry=1: shift mantissa right 1, OR the shifted-out bit into sticky, exp+1.
  - Else: lz = leading zeros counted from the hidden position; shift left by lz, exp-lz.
  - Mantissa all-zero: set the zero tag.
  - in_nan/in_inf are registered as tags.
- Stage 2 (round, round-to-nearest-even):
  - round_up = G & (R | S | frac LSB). Add to {hidden, frac}.
  - If the rounded mantissa reaches 2.0: fraction becomes 0, exp+1.
  - inexact = G|R|S, computed before rounding.
- Stage 2 output selection, in priority order:
  - nan tag: out_data = {0, all ones, 1, zeros}, i.e. 0x7FC0 at defaults.
  - inf tag: {sign, all ones, zeros}.
  - zero tag: +0. The sign is forced to 0.
  - exp >= 2^EXP_W-1: {sign, all ones, zeros} (infinity), out_ovf=1.
  - exp <= 0: {sign, zeros} (flush to signed zero), out_unf=1. Denormals are not produced.
  - Otherwise: {sign, exp[EXP_W-1:0], frac}.
- out_ovf and out_unf are qualified by out_valid and are 0 on bubbles.

Optional Feature:
- Macro: FP_NORM_STATUS_EN.
- Defined:
  - status is a sticky register; bits are OR-set on each output transfer (out_valid & out_ready).
  - status_clr clears it the next cycle.
  - A simultaneous clear and set resolves to set (the new event wins).
- Undefined: status is tied to 0 and status_clr is ignored.

Test Plan:
- Carry normalise: in_exp=127, in_mant=0xC00, sign 0 -> out_data=0x4040 two cycles later; ovf=0, unf=0.
- Left shift: in_exp=130, in_mant=0x100 -> out_data=0x4000.
- Tie-to-even: in_exp=127, in_mant=0x40C -> 0x3F82; in_mant=0x404 -> 0x3F80. Carry-out on rounding: in_mant=0x7FC -> 0x4000. status inexact=1 with FP_NORM_STATUS_EN defined.
- Range limits and zero:
  - in_exp=254, in_mant=0xC00 -> 0x7F80, out_ovf=1.
  - in_sign=1, in_exp=1, in_mant=0x100 -> 0x8000, out_unf=1.
  - in_mant=0 with in_sign=1 -> 0x0000.
- Backpressure: stream 4 beats with out_ready=0 -> out_valid rises after 2 cycles, in_ready falls, out_data holds steady. Raising out_ready drains all 4 in order with no loss or duplication.
- Specials and reset: in_nan=1 -> 0x7FC0; in_inf=1 with sign 1 -> 0xFF80. Assert nreset with 2 beats in flight -> out_valid=0 immediately and no stale beat appears afterwards.
